// File: rtl/dircc_router_pkg.sv
// Shared types for the dircc stream router.
//   port_e      : identifies a router port (local node or network link)
//   out_state_e : per-output packet lock state
//   st_beat_t   : one Avalon-ST beat (payload plus framing)
//   route_dest  : destination decision taken from a packet header
package dircc_router_pkg;

  localparam int ST_DATA_W  = 32;
  localparam int ST_EMPTY_W = 2;
  localparam int NUM_PORTS  = 2;

  typedef enum logic {
    PORT_LOCAL = 1'b0,
    PORT_NET   = 1'b1
  } port_e;

  typedef enum logic {
    OS_IDLE   = 1'b0,
    OS_LOCKED = 1'b1
  } out_state_e;

  typedef struct packed {
    logic [ST_DATA_W-1:0]  data;
    logic                  sop;
    logic                  eop;
    logic [ST_EMPTY_W-1:0] empty;
  } st_beat_t;

  // A header equal to this node's address is delivered locally,
  // everything else is pushed back out onto the network.
  function automatic port_e route_dest(input logic [ST_DATA_W-1:0] hdr,
                                       input logic [ST_DATA_W-1:0] self_addr);
    return (hdr == self_addr) ? PORT_LOCAL : PORT_NET;
  endfunction

endpackage

// File: rtl/dircc_st_pipe_reg.sv
// One-entry Avalon-ST output register.
//   clk, rst_n       : clock, asynchronous active-low reset
//   in_valid/in_beat : beat offered by the router core
//   in_ready         : register can take a beat this cycle (empty or draining)
//   out_valid/out_beat/out_ready : downstream Avalon-ST interface
// Holds its contents unchanged while out_valid && !out_ready, and supports
// one beat per cycle when out_ready stays high.
module dircc_st_pipe_reg
  import dircc_router_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  st_beat_t in_beat,
  output logic     in_ready,
  output logic     out_valid,
  output st_beat_t out_beat,
  input  logic     out_ready
);

  logic     valid_reg;
  st_beat_t beat_reg;

  assign in_ready  = !valid_reg || out_ready;
  assign out_valid = valid_reg;
  assign out_beat  = beat_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      beat_reg  <= '0;
    end else if (in_valid && in_ready) begin
      valid_reg <= 1'b1;
      beat_reg  <= in_beat;
    end else if (out_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/dircc_stream_router.sv
// Two-port packet router between the local processing node and the
// network link. The sop beat of each packet carries the destination
// address; matching packets go to local_out, all others to net_out.
// Each output is locked to one input for a whole packet, with per-output
// round-robin arbitration when both inputs contend.
//   clk_routing_clk, reset_routing_reset_n : clock, async active-low reset
//   address_address        : this node's address, compared at each sop
//   local_in_* / net_in_*  : Avalon-ST sinks (node stream_out, network link)
//   local_out_* / net_out_*: Avalon-ST sources (node stream_in, network link)
//   drop_count             : saturating count of discarded unframed beats
module dircc_stream_router
  import dircc_router_pkg::*;
#(
  parameter int DATA_W  = ST_DATA_W,   // must match the st_beat_t payload width
  parameter int EMPTY_W = ST_EMPTY_W,  // must match the st_beat_t empty width
  parameter int CNT_W   = 16,
  parameter int RR_INIT = 0
) (
  input  logic               clk_routing_clk,
  input  logic               reset_routing_reset_n,
  input  logic [DATA_W-1:0]  address_address,

  input  logic               local_in_valid,
  input  logic [DATA_W-1:0]  local_in_data,
  input  logic               local_in_startofpacket,
  input  logic               local_in_endofpacket,
  input  logic [EMPTY_W-1:0] local_in_empty,
  output logic               local_in_ready,

  input  logic               net_in_valid,
  input  logic [DATA_W-1:0]  net_in_data,
  input  logic               net_in_startofpacket,
  input  logic               net_in_endofpacket,
  input  logic [EMPTY_W-1:0] net_in_empty,
  output logic               net_in_ready,

  output logic               local_out_valid,
  output logic [DATA_W-1:0]  local_out_data,
  output logic               local_out_startofpacket,
  output logic               local_out_endofpacket,
  output logic [EMPTY_W-1:0] local_out_empty,
  input  logic               local_out_ready,

  output logic               net_out_valid,
  output logic [DATA_W-1:0]  net_out_data,
  output logic               net_out_startofpacket,
  output logic               net_out_endofpacket,
  output logic [EMPTY_W-1:0] net_out_empty,
  input  logic               net_out_ready,

  output logic [CNT_W-1:0]   drop_count
);

  // Arrays are indexed by port_e: [0] = local, [1] = net.
  logic       in_valid   [NUM_PORTS];
  st_beat_t   in_beat    [NUM_PORTS];
  logic       in_ready   [NUM_PORTS];
  port_e      dest       [NUM_PORTS];
  logic       engaged    [NUM_PORTS];
  logic       drop       [NUM_PORTS];

  out_state_e state_reg  [NUM_PORTS];
  out_state_e state_next [NUM_PORTS];
  port_e      src_reg    [NUM_PORTS];
  port_e      src_next   [NUM_PORTS];
  logic       rr_reg     [NUM_PORTS];
  logic       rr_next    [NUM_PORTS];

  logic [NUM_PORTS-1:0] req [NUM_PORTS];
  logic       grant      [NUM_PORTS];
  port_e      grant_src  [NUM_PORTS];
  logic       active     [NUM_PORTS];
  port_e      act_src    [NUM_PORTS];
  logic       load       [NUM_PORTS];

  logic       pipe_valid [NUM_PORTS];
  st_beat_t   pipe_beat  [NUM_PORTS];
  logic       can_accept [NUM_PORTS];
  logic       out_valid  [NUM_PORTS];
  st_beat_t   out_beat   [NUM_PORTS];
  logic       out_ready  [NUM_PORTS];

  logic [CNT_W-1:0] drop_count_reg;
  logic [CNT_W-1:0] drop_count_next;
  logic [CNT_W:0]   drop_sum;

  assign in_valid[0] = local_in_valid;
  assign in_valid[1] = net_in_valid;
  assign in_beat[0]  = '{data: local_in_data, sop: local_in_startofpacket,
                         eop: local_in_endofpacket, empty: local_in_empty};
  assign in_beat[1]  = '{data: net_in_data, sop: net_in_startofpacket,
                         eop: net_in_endofpacket, empty: net_in_empty};
  assign out_ready[0] = local_out_ready;
  assign out_ready[1] = net_out_ready;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dest[i]    = route_dest(in_beat[i].data, address_address);
      engaged[i] = 1'b0;
    end

    // An input is mid-packet exactly when some output is locked to it, so
    // the route decision lives in the output lock and address changes
    // after the sop have no effect.
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (state_reg[o] == OS_LOCKED) engaged[src_reg[o]] = 1'b1;
    end

    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = in_valid[i] && in_beat[i].sop && !engaged[i] &&
                    (dest[i] == ((o == 0) ? PORT_LOCAL : PORT_NET));
      end

      grant[o]     = 1'b0;
      grant_src[o] = PORT_LOCAL;
      rr_next[o]   = rr_reg[o];
      if (state_reg[o] == OS_IDLE) begin
        if (req[o][0] && req[o][1]) begin
          grant[o]     = 1'b1;
          grant_src[o] = rr_reg[o] ? PORT_NET : PORT_LOCAL;
          rr_next[o]   = !rr_reg[o];
        end else if (req[o][0]) begin
          grant[o]     = 1'b1;
          grant_src[o] = PORT_LOCAL;
        end else if (req[o][1]) begin
          grant[o]     = 1'b1;
          grant_src[o] = PORT_NET;
        end
      end

      // A grant takes effect in the same cycle, so a single-beat packet
      // can be granted, forwarded and released without leaving IDLE.
      active[o]     = (state_reg[o] == OS_LOCKED) || grant[o];
      act_src[o]    = (state_reg[o] == OS_LOCKED) ? src_reg[o] : grant_src[o];
      pipe_valid[o] = active[o] && in_valid[act_src[o]];
      pipe_beat[o]  = in_beat[act_src[o]];
      load[o]       = pipe_valid[o] && can_accept[o];

      state_next[o] = state_reg[o];
      src_next[o]   = src_reg[o];
      if (active[o]) begin
        src_next[o]   = act_src[o];
        state_next[o] = (load[o] && pipe_beat[o].eop) ? OS_IDLE : OS_LOCKED;
      end
    end

    // Unframed beats on an idle input are swallowed; a pending sop that is
    // not (yet) granted is held off.
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = !engaged[i] && !in_beat[i].sop;
      drop[i]     = in_valid[i] && !engaged[i] && !in_beat[i].sop;
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (active[o]) in_ready[act_src[o]] = can_accept[o];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      in_ready[i] = in_ready[i] && reset_routing_reset_n;
      drop[i]     = drop[i] && reset_routing_reset_n;
    end
  end

  // Both inputs may drop in the same cycle; saturate rather than wrap.
  always_comb begin
    drop_sum = {1'b0, drop_count_reg}
             + {{CNT_W{1'b0}}, drop[0]}
             + {{CNT_W{1'b0}}, drop[1]};
    drop_count_next = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_routing_clk or negedge reset_routing_reset_n) begin
    if (!reset_routing_reset_n) begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_reg[o] <= OS_IDLE;
        src_reg[o]   <= PORT_LOCAL;
        rr_reg[o]    <= (RR_INIT != 0);
      end
      drop_count_reg <= '0;
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        state_reg[o] <= state_next[o];
        src_reg[o]   <= src_next[o];
        rr_reg[o]    <= rr_next[o];
      end
      drop_count_reg <= drop_count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      dircc_st_pipe_reg u_pipe (
        .clk       (clk_routing_clk),
        .rst_n     (reset_routing_reset_n),
        .in_valid  (pipe_valid[gi]),
        .in_beat   (pipe_beat[gi]),
        .in_ready  (can_accept[gi]),
        .out_valid (out_valid[gi]),
        .out_beat  (out_beat[gi]),
        .out_ready (out_ready[gi])
      );
    end
  endgenerate

  assign local_in_ready          = in_ready[0];
  assign net_in_ready            = in_ready[1];

  assign local_out_valid         = out_valid[0];
  assign local_out_data          = out_beat[0].data;
  assign local_out_startofpacket = out_beat[0].sop;
  assign local_out_endofpacket   = out_beat[0].eop;
  assign local_out_empty         = out_beat[0].empty;

  assign net_out_valid           = out_valid[1];
  assign net_out_data            = out_beat[1].data;
  assign net_out_startofpacket   = out_beat[1].sop;
  assign net_out_endofpacket     = out_beat[1].eop;
  assign net_out_empty           = out_beat[1].empty;

  assign drop_count              = drop_count_reg;

endmodule

// File: tb/tb_dircc_stream_router.sv
module tb_dircc_stream_router;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] addr;

  logic        li_valid, li_sop, li_eop, li_ready;
  logic [31:0] li_data;
  logic [1:0]  li_empty;
  logic        ni_valid, ni_sop, ni_eop, ni_ready;
  logic [31:0] ni_data;
  logic [1:0]  ni_empty;
  logic        lo_valid, lo_sop, lo_eop, lo_ready;
  logic [31:0] lo_data;
  logic [1:0]  lo_empty;
  logic        no_valid, no_sop, no_eop, no_ready;
  logic [31:0] no_data;
  logic [1:0]  no_empty;
  logic [15:0] drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } exp_t;

  exp_t exp_local_q[$];
  exp_t exp_net_q[$];
  exp_t e_l, e_n;

  dircc_stream_router dut (
    .clk_routing_clk         (clk),
    .reset_routing_reset_n   (rst_n),
    .address_address         (addr),
    .local_in_valid          (li_valid),
    .local_in_data           (li_data),
    .local_in_startofpacket  (li_sop),
    .local_in_endofpacket    (li_eop),
    .local_in_empty          (li_empty),
    .local_in_ready          (li_ready),
    .net_in_valid            (ni_valid),
    .net_in_data             (ni_data),
    .net_in_startofpacket    (ni_sop),
    .net_in_endofpacket      (ni_eop),
    .net_in_empty            (ni_empty),
    .net_in_ready            (ni_ready),
    .local_out_valid         (lo_valid),
    .local_out_data          (lo_data),
    .local_out_startofpacket (lo_sop),
    .local_out_endofpacket   (lo_eop),
    .local_out_empty         (lo_empty),
    .local_out_ready         (lo_ready),
    .net_out_valid           (no_valid),
    .net_out_data            (no_data),
    .net_out_startofpacket   (no_sop),
    .net_out_endofpacket     (no_eop),
    .net_out_empty           (no_empty),
    .net_out_ready           (no_ready),
    .drop_count              (drop_count)
  );

  // Beat k of a packet from input 'port': header first, then a tag that
  // identifies the source input and beat number.
  function automatic logic [31:0] beat_data(input int port, input logic [31:0] hdr, input int k);
    if (k == 0) return hdr;
    return 32'hA000_0000 | (32'(port) << 16) | 32'(k);
  endfunction

  function automatic exp_t beat_of(input int port, input logic [31:0] hdr, input int k, input int n);
    exp_t b;
    b.data  = beat_data(port, hdr, k);
    b.sop   = (k == 0);
    b.eop   = (k == n - 1);
    b.empty = 2'(k);
    return b;
  endfunction

  function automatic bit rdy(input int port);
    return (port == 0) ? li_ready : ni_ready;
  endfunction

  task automatic push_pkt(input int out_port, input int in_port, input logic [31:0] hdr, input int n);
    for (int k = 0; k < n; k++) begin
      if (out_port == 0) exp_local_q.push_back(beat_of(in_port, hdr, k, n));
      else               exp_net_q.push_back(beat_of(in_port, hdr, k, n));
    end
  endtask

  task automatic set_in(input int port, input logic v, input exp_t b);
    if (port == 0) begin
      li_valid = v; li_data = b.data; li_sop = b.sop; li_eop = b.eop; li_empty = b.empty;
    end else begin
      ni_valid = v; ni_data = b.data; ni_sop = b.sop; ni_eop = b.eop; ni_empty = b.empty;
    end
  endtask

  // Called and returns at posedge+1; 'cycles' is clock cycles used.
  task automatic send_pkt(input int port, input logic [31:0] hdr, input int n, output int cycles);
    bit done;
    cycles = 0;
    for (int k = 0; k < n; k++) begin
      set_in(port, 1'b1, beat_of(port, hdr, k, n));
      done = 1'b0;
      while (!done) begin
        @(negedge clk);
        cycles++;
        if (rdy(port)) begin
          done = 1'b1;
        end else if (cycles > 200) begin
          n_checks++; n_fail++;
          $display("FAIL send_timeout: port %0d beat %0d ready=0 after %0d cycles, expected ready=1",
                   port, k, cycles);
          set_in(port, 1'b0, '0);
          return;
        end
        @(posedge clk); #1;
      end
    end
    set_in(port, 1'b0, '0);
  endtask

  // Scoreboard: every beat that leaves an output must be the next expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      if (lo_valid && lo_ready) begin
        n_checks++;
        if (exp_local_q.size() == 0) begin
          n_fail++;
          $display("FAIL local_out_beat: got unexpected beat data=%h, expected no beat", lo_data);
        end else begin
          e_l = exp_local_q.pop_front();
          if ({lo_data, lo_sop, lo_eop, lo_empty} !== e_l) begin
            n_fail++;
            $display("FAIL local_out_beat: got %h/%b/%b/%h, expected %h/%b/%b/%h",
                     lo_data, lo_sop, lo_eop, lo_empty, e_l.data, e_l.sop, e_l.eop, e_l.empty);
          end
        end
      end
      if (no_valid && no_ready) begin
        n_checks++;
        if (exp_net_q.size() == 0) begin
          n_fail++;
          $display("FAIL net_out_beat: got unexpected beat data=%h, expected no beat", no_data);
        end else begin
          e_n = exp_net_q.pop_front();
          if ({no_data, no_sop, no_eop, no_empty} !== e_n) begin
            n_fail++;
            $display("FAIL net_out_beat: got %h/%b/%b/%h, expected %h/%b/%b/%h",
                     no_data, no_sop, no_eop, no_empty, e_n.data, e_n.sop, e_n.eop, e_n.empty);
          end
        end
      end
    end
  end

  task automatic drain();
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; addr = 32'h5;
    set_in(0, 1'b0, '0); set_in(1, 1'b0, '0);
    lo_ready = 1'b1; no_ready = 1'b1;
    #2;
    n_checks++;
    if ({lo_valid, no_valid} !== 2'b00) begin
      n_fail++; $display("FAIL reset_valid: got %b, expected 00", {lo_valid, no_valid});
    end
    n_checks++;
    if ({lo_data, lo_sop, lo_eop, lo_empty, no_data, no_sop, no_eop, no_empty} !== 72'h0) begin
      n_fail++; $display("FAIL reset_out_fields: got nonzero output fields, expected all 0");
    end
    n_checks++;
    if (drop_count !== 16'h0) begin
      n_fail++; $display("FAIL reset_drop_count: got %h, expected 0000", drop_count);
    end
    n_checks++;
    if ({li_ready, ni_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_in_ready: got %b, expected 00", {li_ready, ni_ready});
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_local_delivery();
    int cyc;
    addr = 32'h5;
    push_pkt(0, 1, 32'h5, 3);
    send_pkt(1, 32'h5, 3, cyc);
    n_checks++;
    if (cyc !== 3) begin
      n_fail++; $display("FAIL deliver_cycles: got %0d, expected 3", cyc);
    end
    @(negedge clk);
    n_checks++;
    if ({lo_valid, lo_eop, lo_data, no_valid} !== {1'b1, 1'b1, beat_data(1, 32'h5, 2), 1'b0}) begin
      n_fail++;
      $display("FAIL deliver_latency: got valid=%b eop=%b data=%h net_valid=%b, expected 1 1 %h 0",
               lo_valid, lo_eop, lo_data, no_valid, beat_data(1, 32'h5, 2));
    end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (lo_valid !== 1'b0) begin
      n_fail++; $display("FAIL deliver_idle: got local_out_valid=%b, expected 0", lo_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_concurrent();
    int c0, c1;
    push_pkt(1, 0, 32'h9, 3);
    push_pkt(0, 1, 32'h5, 3);
    fork
      send_pkt(0, 32'h9, 3, c0);
      send_pkt(1, 32'h5, 3, c1);
    join
    n_checks++;
    if ({c0, c1} !== {32'd3, 32'd3}) begin
      n_fail++; $display("FAIL concurrent_cycles: got local=%0d net=%0d, expected 3 3", c0, c1);
    end
    drain();
  endtask

  task automatic test_arbitration();
    int c0, c1;
    // Round 1: pointer favours local.
    push_pkt(1, 0, 32'h7, 2);
    push_pkt(1, 1, 32'h7, 2);
    fork
      send_pkt(0, 32'h7, 2, c0);
      send_pkt(1, 32'h7, 2, c1);
      begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          n_checks++;
          if (ni_ready !== 1'b0) begin
            n_fail++; $display("FAIL arb1_loser_ready: cycle %0d got net_in_ready=%b, expected 0", c, ni_ready);
          end
        end
      end
    join
    n_checks++;
    if ({c0, c1} !== {32'd2, 32'd4}) begin
      n_fail++; $display("FAIL arb1_cycles: got local=%0d net=%0d, expected 2 4", c0, c1);
    end
    drain();
    // Round 2: pointer has moved to net.
    push_pkt(1, 1, 32'h7, 2);
    push_pkt(1, 0, 32'h7, 2);
    fork
      send_pkt(0, 32'h7, 2, c0);
      send_pkt(1, 32'h7, 2, c1);
      begin
        for (int c = 0; c < 2; c++) begin
          @(negedge clk);
          n_checks++;
          if (li_ready !== 1'b0) begin
            n_fail++; $display("FAIL arb2_loser_ready: cycle %0d got local_in_ready=%b, expected 0", c, li_ready);
          end
        end
      end
    join
    n_checks++;
    if ({c0, c1} !== {32'd4, 32'd2}) begin
      n_fail++; $display("FAIL arb2_cycles: got local=%0d net=%0d, expected 4 2", c0, c1);
    end
    drain();
  endtask

  task automatic test_backpressure();
    int c1;
    push_pkt(0, 1, 32'h5, 4);
    fork
      send_pkt(1, 32'h5, 4, c1);
      begin
        @(posedge clk); #1;
        lo_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          n_checks++;
          if ({lo_valid, lo_sop, lo_data, ni_ready} !== {1'b1, 1'b1, beat_data(1, 32'h5, 0), 1'b0}) begin
            n_fail++;
            $display("FAIL stall_hold: cycle %0d got valid=%b sop=%b data=%h in_ready=%b, expected 1 1 %h 0",
                     c, lo_valid, lo_sop, lo_data, ni_ready, beat_data(1, 32'h5, 0));
          end
        end
        @(posedge clk); #1;
        lo_ready = 1'b1;
      end
    join
    n_checks++;
    if (c1 !== 9) begin
      n_fail++; $display("FAIL stall_cycles: got %0d, expected 9", c1);
    end
    drain();
  endtask

  task automatic test_drops();
    exp_t junk;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    junk = '{data: 32'h1234_0000, sop: 1'b0, eop: 1'b0, empty: 2'b00};
    set_in(1, 1'b1, junk);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (ni_ready !== 1'b1) begin
        n_fail++; $display("FAIL drop_ready: beat %0d got net_in_ready=%b, expected 1", c, ni_ready);
      end
      @(posedge clk); #1;
    end
    set_in(1, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if ({drop_count, lo_valid, no_valid} !== {16'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL drop_count3: got count=%0d lo_valid=%b no_valid=%b, expected 3 0 0",
                         drop_count, lo_valid, no_valid);
    end
    @(posedge clk); #1;
    // Both inputs dropping together count two per cycle.
    set_in(0, 1'b1, junk);
    set_in(1, 1'b1, junk);
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'd5) begin
      n_fail++; $display("FAIL drop_count_dual: got %0d, expected 5", drop_count);
    end
    repeat (32765) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL drop_count_max: got %h, expected ffff", drop_count);
    end
    repeat (3) @(posedge clk);
    #1;
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'hFFFF) begin
      n_fail++; $display("FAIL drop_count_sat: got %h, expected ffff", drop_count);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_packet();
    int c1;
    exp_t junk;
    addr = 32'h5;
    exp_local_q.push_back(beat_of(1, 32'h5, 0, 4));
    for (int k = 0; k < 2; k++) begin
      set_in(1, 1'b1, beat_of(1, 32'h5, k, 4));
      @(negedge clk);
      n_checks++;
      if (ni_ready !== 1'b1) begin
        n_fail++; $display("FAIL midrst_ready: beat %0d got %b, expected 1", k, ni_ready);
      end
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    set_in(1, 1'b0, '0);
    #1;
    n_checks++;
    if ({lo_valid, lo_data, no_valid, drop_count} !== {1'b0, 32'h0, 1'b0, 16'h0}) begin
      n_fail++; $display("FAIL midrst_clear: got lo_valid=%b lo_data=%h no_valid=%b count=%h, expected 0 0 0 0",
                         lo_valid, lo_data, no_valid, drop_count);
    end
    n_checks++;
    if ({li_ready, ni_ready} !== 2'b00) begin
      n_fail++; $display("FAIL midrst_in_ready: got %b, expected 00", {li_ready, ni_ready});
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    junk = '{data: 32'hDEAD_0000, sop: 1'b0, eop: 1'b0, empty: 2'b00};
    set_in(1, 1'b1, junk);
    @(posedge clk); #1;
    set_in(1, 1'b0, '0);
    @(negedge clk);
    n_checks++;
    if (drop_count !== 16'd1) begin
      n_fail++; $display("FAIL midrst_lead_drop: got %0d, expected 1", drop_count);
    end
    @(posedge clk); #1;
    push_pkt(0, 1, 32'h5, 2);
    send_pkt(1, 32'h5, 2, c1);
    n_checks++;
    if (c1 !== 2) begin
      n_fail++; $display("FAIL midrst_new_pkt_cycles: got %0d, expected 2", c1);
    end
    drain();
  endtask

  initial begin
    test_reset();
    $display("test_reset done: checks=%0d failures=%0d", n_checks, n_fail);
    test_local_delivery();
    $display("test_local_delivery done: checks=%0d failures=%0d", n_checks, n_fail);
    test_concurrent();
    $display("test_concurrent done: checks=%0d failures=%0d", n_checks, n_fail);
    test_arbitration();
    $display("test_arbitration done: checks=%0d failures=%0d", n_checks, n_fail);
    test_backpressure();
    $display("test_backpressure done: checks=%0d failures=%0d", n_checks, n_fail);
    test_drops();
    $display("test_drops done: checks=%0d failures=%0d", n_checks, n_fail);
    test_reset_mid_packet();
    $display("test_reset_mid_packet done: checks=%0d failures=%0d", n_checks, n_fail);
    n_checks++;
    if (exp_local_q.size() != 0) begin
      n_fail++; $display("FAIL local_queue_empty: got %0d pending beats, expected 0", exp_local_q.size());
    end
    n_checks++;
    if (exp_net_q.size() != 0) begin
      n_fail++; $display("FAIL net_queue_empty: got %0d pending beats, expected 0", exp_net_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
